// File: rtl/sevenseg_scan_if.sv
// Display-side bundle for sevenseg_scan.
// The master drives the value/dp/blank request and scan enable.
// The slave (the scanner) drives the multiplexed segment and anode pins.
interface sevenseg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;

  modport master (output en, value, dp_in, blank, input seg, dp, an);
  modport slave  (input en, value, dp_in, blank, output seg, dp, an);
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit hex seven-segment scanner.
// The displayed value is snapshotted once per frame so that a frame is never torn.
// Each digit slot is dark for its first clock, which prevents ghosting.
// All pins are registered, and output polarity is applied after blanking.
module sevenseg_scan #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sevenseg_scan_if.slave    bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

  // Hex nibble to segment pattern; the bit order is gfedcba and bits are active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpsh_q, dpsh_d;
  logic [DIGITS-1:0]   blsh_q, blsh_d;
  logic                load_pending_q, load_pending_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic                snap;
  logic                lz_zero;
  logic                dark;

  // Scan timing: the prescaler, the digit index and the frame-start snapshot of the inputs.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave a value unassigned and infer a latch.
    presc_d        = presc_q;
    idx_d          = idx_q;
    val_d          = val_q;
    dpsh_d         = dpsh_q;
    blsh_d         = blsh_q;
    load_pending_d = load_pending_q;

    tick = bus.en && (presc_q == CNT_LAST);
    snap = (load_pending_q && bus.en) || (tick && (idx_q == IDX_LAST));

    if (bus.en) begin
      presc_d        = tick ? '0 : presc_q + 1'b1;
      load_pending_d = 1'b0;
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (snap) begin
      val_d  = bus.value;
      dpsh_d = bus.dp_in;
      blsh_d = bus.blank;
    end
  end

  // Digit output: apply blanking, leading-zero suppression and dead-time, then polarity.
  always_comb begin
    lz_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((IDX_W'(k) >= idx_q) && (val_q[4*k +: 4] != 4'h0)) begin
        lz_zero = 1'b0;
      end
    end

    dark = !bus.en || (presc_q == '0) || blsh_q[idx_q] ||
           (LZ_BLANK && (idx_q != '0) && lz_zero);

    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (!dark) begin
      seg_d = hex_to_seg(val_q[4*idx_q +: 4]) ^ SEG_OFF;
      dp_d  = dpsh_q[idx_q] ^ DP_OFF;
      an_d  = (DIGITS'(1) << idx_q) ^ AN_OFF;
    end
  end

  // State and output registers, with synchronous reset to the idle and all-off state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow registers are plain flops rather than a memory, so they are reset to a known zero frame.
      presc_q        <= '0;
      idx_q          <= '0;
      val_q          <= '0;
      dpsh_q         <= '0;
      blsh_q         <= '0;
      load_pending_q <= 1'b1;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      an_q           <= AN_OFF;
    end else begin
      // NOTE: non-blocking assignments make every register sample its pre-edge value together.
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      val_q          <= val_d;
      dpsh_q         <= dpsh_d;
      blsh_q         <= blsh_d;
      load_pending_q <= load_pending_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      an_q           <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.an  = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan.
// Two instances share one stimulus stream:
//   a: plain polarity, active-low anodes, no leading-zero suppression.
//   b: inverted segments, active-high anodes, leading-zero suppression on.
// The reference model tracks a frame position and a snapshot of the inputs.
module tb_sevenseg_scan;

  localparam int DIGITS_T = 4;
  localparam int DIV_T    = 4;
  localparam int FRAME    = DIGITS_T * DIV_T;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank;

  int total;
  int bad;

  // Reference model state
  int          pos;
  bit          pend;
  logic [15:0] sh_val;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_bl;

  sevenseg_scan_if #(.DIGITS(DIGITS_T)) if_a ();
  sevenseg_scan_if #(.DIGITS(DIGITS_T)) if_b ();

  assign if_a.en    = en;
  assign if_a.value = value;
  assign if_a.dp_in = dp_in;
  assign if_a.blank = blank;
  assign if_b.en    = en;
  assign if_b.value = value;
  assign if_b.dp_in = dp_in;
  assign if_b.blank = blank;

  sevenseg_scan #(
    .DIGITS(DIGITS_T), .DIV(DIV_T), .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );

  sevenseg_scan #(
    .DIGITS(DIGITS_T), .DIV(DIV_T), .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Expected pins after the next edge, given the current model state and inputs.
  function automatic void model_out(input bit seg_low, input bit an_low, input bit lz,
                                    output logic [6:0] s, output logic d,
                                    output logic [3:0] a);
    int  dig = pos / DIV_T;
    int  ph  = pos % DIV_T;
    bit  dark;
    dark = rst || !en || (ph == 0) || sh_bl[dig] ||
           (lz && (dig > 0) && ((sh_val >> (4 * dig)) == 16'h0));
    s = dark ? 7'h00 : SEG_TAB[sh_val[4*dig +: 4]];
    d = dark ? 1'b0  : sh_dp[dig];
    a = dark ? 4'h0  : 4'(1 << dig);
    if (seg_low) begin
      s = ~s;
      d = ~d;
    end
    if (an_low) a = ~a;
  endfunction

  task automatic model_step();
    if (rst) begin
      pos    = 0;
      pend   = 1'b1;
      sh_val = '0;
      sh_dp  = '0;
      sh_bl  = '0;
    end else if (en) begin
      if (pend || (pos == FRAME - 1)) begin
        sh_val = value;
        sh_dp  = dp_in;
        sh_bl  = blank;
      end
      pend = 1'b0;
      pos  = (pos + 1) % FRAME;
    end
  endtask

  task automatic cycle();
    logic [6:0] sa, sb;
    logic       da, db;
    logic [3:0] aa, ab;
    model_out(1'b0, 1'b1, 1'b0, sa, da, aa);
    model_out(1'b1, 1'b0, 1'b1, sb, db, ab);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("seg_a", {1'b0, if_a.seg}, {1'b0, sa});
    check("dp_a",  {7'b0, if_a.dp},  {7'b0, da});
    check("an_a",  {4'b0, if_a.an},  {4'b0, aa});
    check("seg_b", {1'b0, if_b.seg}, {1'b0, sb});
    check("dp_b",  {7'b0, if_b.dp},  {7'b0, db});
    check("an_b",  {4'b0, if_b.an},  {4'b0, ab});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pos    = 0;
    pend   = 1'b1;
    sh_val = '0;
    sh_dp  = '0;
    sh_bl  = '0;
    rst    = 1'b1;
    en     = 1'b0;
    value  = '0;
    dp_in  = '0;
    blank  = '0;

    // Reset is held for three clocks and every pin must read its off level.
    run(3);
    check("rst_an_a",  {4'b0, if_a.an},  8'h0F);
    check("rst_seg_a", {1'b0, if_a.seg}, 8'h00);
    check("rst_an_b",  {4'b0, if_b.an},  8'h00);
    check("rst_seg_b", {1'b0, if_b.seg}, 8'h7F);

    // Normal scan of value 1234 with a decimal point on digit 2.
    rst   = 1'b0;
    en    = 1'b1;
    value = 16'h1234;
    dp_in = 4'b0100;
    run(2 * FRAME);

    // The value changes mid-frame. The current frame must not tear.
    value = 16'hABCD;
    dp_in = 4'b0000;
    run(FRAME + 6);
    value = 16'h0000;
    run(2 * FRAME);

    // Leading-zero cases, which instance b suppresses.
    value = 16'h0050;
    run(2 * FRAME);
    value = 16'h0000;
    run(2 * FRAME);

    // Digit 1 is forced dark while every decimal point is requested.
    value = 16'h1238;
    dp_in = 4'b1111;
    blank = 4'b0010;
    run(2 * FRAME);
    blank = 4'b0000;
    dp_in = 4'b0000;

    // Enable is dropped in the middle of a slot, then scanning resumes.
    value = 16'h9E7F;
    run(FRAME + 6);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(FRAME);

    // Reset is asserted in the middle of a frame while enable stays high.
    run(5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) begin
        value = 16'($urandom);
        dp_in = 4'($urandom);
        blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      end
      if ($urandom_range(7) == 0) value = 16'($urandom_range(255));
      en  = ($urandom_range(9) != 0);
      rst = ($urandom_range(99) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Parametrised, time-multiplexed N-digit hex seven-segment display driver, the successor to the single-digit combinational decoder.
- Snapshots a packed hex value once per frame and scans one digit at a time via shared segment lines plus per-digit anode enables.
- Adds per-digit decimal points, blanking, leading-zero suppression, a dead-time slot against ghosting, and configurable output polarity.
- Sits between the datapath/debug registers and the board's display pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- DIV, 1000, clocks per digit slot; must be >= 2.
- SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the output register.
- AN_ACTIVE_LOW, 1, 1 inverts an at the output register.
- LZ_BLANK, 0, 1 enables leading-zero suppression.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable.
- value, input, 4*DIGITS, hex nibbles; digit k = value[4k+3:4k], digit 0 is rightmost.
- dp_in, input, DIGITS, decimal point request per digit.
- blank, input, DIGITS, force digit k dark (segments and dp off).
- seg, output, 7, segments, bit0=a .. bit6=g.
- dp, output, 1, decimal point.
- an, output, DIGITS, digit enables; one-hot when active.

Behaviour:
- Clock/reset: single clock domain; reset is synchronous and active-high on rst. All state changes on the rising clk edge.
- Reset values: prescaler=0, idx=0, shadow value/dp/blank=0, load_pending=1. Outputs inactive: seg, dp and an all at their "off" level after polarity (e.g. an all 1s when AN_ACTIVE_LOW=1).
- Prescaler: counts 0..DIV-1 while en=1 and wraps to 0.
  - A tick occurs when prescaler==DIV-1 and en=1.
  - On a tick, idx advances to (idx+1) mod DIGITS; DIGITS-1 wraps to 0.
- Snapshot: value, dp_in and blank are copied into shadow registers when either condition holds:
  - load_pending=1 and en=1 (this clears load_pending), or
  - a tick where idx==DIGITS-1, i.e. at frame start.
  - Input changes mid-frame never tear a displayed frame.
- Decode: shadow nibble for idx maps to segments (gfedcba, active-high before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Digit dark when any of the following holds:
  - shadow blank[idx]=1;
  - LZ_BLANK=1, idx>0, and nibbles idx..DIGITS-1 are all zero (digit 0 is never suppressed);
  - dead-time: prescaler==0, the first clock of each slot.
  - A dark digit drives seg=0, dp=0 and all an off.
- Lit digit: an bit idx is on (all other bits off), seg is the decoded value, dp equals shadow dp_in[idx].
- Latency: outputs are registered one clock after the (prescaler, idx, shadow) state they reflect.
- en=0: prescaler and idx hold, no snapshot occurs, and outputs go fully inactive on the next clock. When en returns, scanning resumes from the held state.
- Reset mid-frame: takes effect on the next edge regardless of en; the frame is abandoned and scanning restarts at digit 0 with a fresh snapshot.
- Polarity inversion is applied last, after blanking; "off" always means the inactive electrical level.

Test Plan:
- Reset with DIGITS=4, DIV=4, AN_ACTIVE_LOW=1: hold rst 3 clks -> an=1111, seg=0000000, dp=0. After release with en=1, an=1110 (digit 0 lit) from the second slot clock onward; full frame is 16 clks.
- value=16'h1234, dp_in=0100 -> digits show 4=66, 3=4F, 2=5B (dp=1), 1=06 in that order. Each digit is dark for 1 clk, then lit for 3 clks.
- value=16'hABCD, then changed to 16'h0000 mid-frame -> the current frame still shows 5E/39/7C/77; the next frame shows 3F on all digits.
- LZ_BLANK=1, value=16'h0050 -> digits 3 and 2 dark, digit 1 seg=6D, digit 0 seg=3F. With value=0, only digit 0 shows 3F.
- blank=0010, SEG_ACTIVE_LOW=1 -> digit 1 has seg=1111111 and dp=1 with an off; other digits show inverted patterns (digit 0 with nibble 8 -> 0000000).
- en dropped for 10 clks mid-slot -> outputs inactive, idx/prescaler frozen. After re-enable, the same digit resumes with the remaining slot time; rst asserted mid-frame -> an off next clk, restart at digit 0.
